// File: rtl/game_state_controller.sv
// Game-state keeper between physics and display/audio: BCD score with pending-point drain,
// lives with extra-life awards, timed level loading, win/lose state and prioritised audio cues.
module game_state_controller #(
   parameter int unsigned SCORE_DIGITS     = 4,
   parameter int unsigned LIVES_WIDTH      = 3,
   parameter int unsigned START_LIVES      = 5,
   parameter int unsigned MAX_LIVES        = 7,
   parameter int unsigned EXTRA_LIFE_DIGIT = 3,
   parameter int unsigned ROW_COUNT        = 6,
   parameter int unsigned PENDING_WIDTH    = 6,
   parameter int unsigned LEVEL_COUNT      = 4,
   parameter int unsigned LEVEL_WIDTH      = 2,
   parameter int unsigned WRAP_LEVELS      = 1,
   parameter int unsigned LOAD_CYCLES      = 16,
   parameter int unsigned SAMPLE_WIDTH     = 4
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      STEP_COMPLETE,
   input  logic                      BALL_LOST,
   input  logic                      HIT_BLOCK,
   input  logic [2:0]                HIT_BLOCK_ROW,
   input  logic                      HIT_PADDLE,
   input  logic                      HIT_WALL,
   input  logic                      LEVEL_CLEARED,
   input  logic                      IGNORE_DEATH,
   output logic                      LOAD_LEVEL,
   output logic [LEVEL_WIDTH-1:0]    LEVEL,
   output logic [LIVES_WIDTH-1:0]    LIVES,
   output logic [4*SCORE_DIGITS-1:0] SCORE,
   output logic [SAMPLE_WIDTH-1:0]   AUDIO_SELECT,
   output logic                      AUDIO_TRIGGER,
   output logic                      GAME_OVER,
   output logic                      GAME_WON
);

   typedef enum logic [1:0] {StPlay, StLoad, StOver, StWon} state_e;

   localparam int unsigned LoadCntWidth = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
   localparam logic [LoadCntWidth-1:0] LoadInit = LoadCntWidth'(LOAD_CYCLES - 1);
   localparam int unsigned PendMax = (32'd1 << PENDING_WIDTH) - 32'd1;
   localparam logic [LIVES_WIDTH-1:0] MaxLives = LIVES_WIDTH'(MAX_LIVES);
   localparam logic [LIVES_WIDTH-1:0] StartLives = LIVES_WIDTH'(START_LIVES);
   localparam logic [LEVEL_WIDTH-1:0] LastLevel = LEVEL_WIDTH'(LEVEL_COUNT - 1);

   state_e                    state_q, state_d;
   logic [LIVES_WIDTH-1:0]    lives_q, lives_d;
   logic [LEVEL_WIDTH-1:0]    level_q, level_d;
   logic [4*SCORE_DIGITS-1:0] score_q, score_d;
   logic [PENDING_WIDTH-1:0]  pend_q, pend_d;
   logic [LoadCntWidth-1:0]   load_cnt_q, load_cnt_d;
   logic                      load_level_q, load_level_d;
   logic                      trig_q, trig_d;
   logic [SAMPLE_WIDTH-1:0]   sel_q, sel_d;

   logic        acted, loss, award, carry, all_nines, score_inc;
   logic [31:0] pts, pend_sum;

   always_comb begin
      acted = STEP_COMPLETE && (state_q == StPlay);

      // Pending points: saturating add of block points, then drain one per cycle
      pts = 32'd0;
      if (acted && HIT_BLOCK && (32'(HIT_BLOCK_ROW) < ROW_COUNT)) begin
         pts = ROW_COUNT - 32'(HIT_BLOCK_ROW);
      end
      pend_sum = 32'(pend_q) + pts;
      if (pend_sum > PendMax) pend_sum = PendMax;
      if (pend_q != '0) pend_sum = pend_sum - 32'd1;
      pend_d = PENDING_WIDTH'(pend_sum);

      // BCD ripple increment; the score freezes at all-9s instead of wrapping
      all_nines = 1'b1;
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
         if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      end
      score_inc = (pend_q != '0) && !all_nines;
      score_d   = score_q;
      award     = 1'b0;
      carry     = score_inc;
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
         if ((i == EXTRA_LIFE_DIGIT) && carry) award = 1'b1;
         if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_d[4*i +: 4] = 4'd0;
            end else begin
               score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end

      loss    = acted && BALL_LOST && !IGNORE_DEATH && (lives_q != '0);
      lives_d = lives_q;
      if (award && !loss) begin
         if (lives_q < MaxLives) lives_d = lives_q + 1'b1;
      end else if (loss && !award) begin
         lives_d = lives_q - 1'b1;
      end

      trig_d = acted && (BALL_LOST || HIT_BLOCK || HIT_PADDLE || HIT_WALL);
      sel_d  = sel_q;
      if (trig_d) begin
         if (BALL_LOST)       sel_d = SAMPLE_WIDTH'(2);
         else if (HIT_BLOCK)  sel_d = SAMPLE_WIDTH'(32'd3 + 32'(HIT_BLOCK_ROW));
         else if (HIT_PADDLE) sel_d = SAMPLE_WIDTH'(1);
         else                 sel_d = SAMPLE_WIDTH'(0);
      end

      state_d      = state_q;
      level_d      = level_q;
      load_cnt_d   = load_cnt_q;
      load_level_d = 1'b0;
      case (state_q)
         StPlay: begin
            // Losing the last life takes precedence over clearing the level
            if (lives_d == '0) begin
               state_d = StOver;
            end else if (LEVEL_CLEARED) begin
               if ((level_q == LastLevel) && (WRAP_LEVELS == 0)) begin
                  state_d = StWon;
               end else begin
                  state_d      = StLoad;
                  level_d      = (level_q == LastLevel) ? '0 : level_q + 1'b1;
                  load_level_d = 1'b1;
                  load_cnt_d   = LoadInit;
               end
            end
         end
         StLoad: begin
            if (load_cnt_q == '0) state_d = StPlay;
            else                  load_cnt_d = load_cnt_q - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= StPlay;
         lives_q      <= StartLives;
         level_q      <= '0;
         score_q      <= '0;
         pend_q       <= '0;
         load_cnt_q   <= '0;
         load_level_q <= 1'b0;
         trig_q       <= 1'b0;
         sel_q        <= '0;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         level_q      <= level_d;
         score_q      <= score_d;
         pend_q       <= pend_d;
         load_cnt_q   <= load_cnt_d;
         load_level_q <= load_level_d;
         trig_q       <= trig_d;
         sel_q        <= sel_d;
      end
   end

   assign LOAD_LEVEL    = load_level_q;
   assign LEVEL         = level_q;
   assign LIVES         = lives_q;
   assign SCORE         = score_q;
   assign AUDIO_SELECT  = sel_q;
   assign AUDIO_TRIGGER = trig_q;
   assign GAME_OVER     = (state_q == StOver) || (state_q == StWon);
   assign GAME_WON      = (state_q == StWon);

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: a wrapping instance plus a non-wrapping one
// driven by the same stimulus.
module tb_game_state_controller;

   logic        CLK;
   logic        RESET, STEP_COMPLETE, BALL_LOST, HIT_BLOCK, HIT_PADDLE, HIT_WALL;
   logic        LEVEL_CLEARED, IGNORE_DEATH;
   logic [2:0]  HIT_BLOCK_ROW;

   logic        load_level, audio_trig, game_over, game_won;
   logic [1:0]  level;
   logic [2:0]  lives;
   logic [15:0] score;
   logic [3:0]  audio_sel;

   logic        load_level_nw, audio_trig_nw, game_over_nw, game_won_nw;
   logic [1:0]  level_nw;
   logic [2:0]  lives_nw;
   logic [15:0] score_nw;
   logic [3:0]  audio_sel_nw;

   int tests = 0;
   int fails = 0;
   int pulses;

   game_state_controller dut (
      .CLK(CLK), .RESET(RESET), .STEP_COMPLETE(STEP_COMPLETE), .BALL_LOST(BALL_LOST),
      .HIT_BLOCK(HIT_BLOCK), .HIT_BLOCK_ROW(HIT_BLOCK_ROW), .HIT_PADDLE(HIT_PADDLE),
      .HIT_WALL(HIT_WALL), .LEVEL_CLEARED(LEVEL_CLEARED), .IGNORE_DEATH(IGNORE_DEATH),
      .LOAD_LEVEL(load_level), .LEVEL(level), .LIVES(lives), .SCORE(score),
      .AUDIO_SELECT(audio_sel), .AUDIO_TRIGGER(audio_trig), .GAME_OVER(game_over),
      .GAME_WON(game_won)
   );

   game_state_controller #(.WRAP_LEVELS(0)) dut_nw (
      .CLK(CLK), .RESET(RESET), .STEP_COMPLETE(STEP_COMPLETE), .BALL_LOST(BALL_LOST),
      .HIT_BLOCK(HIT_BLOCK), .HIT_BLOCK_ROW(HIT_BLOCK_ROW), .HIT_PADDLE(HIT_PADDLE),
      .HIT_WALL(HIT_WALL), .LEVEL_CLEARED(LEVEL_CLEARED), .IGNORE_DEATH(IGNORE_DEATH),
      .LOAD_LEVEL(load_level_nw), .LEVEL(level_nw), .LIVES(lives_nw), .SCORE(score_nw),
      .AUDIO_SELECT(audio_sel_nw), .AUDIO_TRIGGER(audio_trig_nw), .GAME_OVER(game_over_nw),
      .GAME_WON(game_won_nw)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic step(input logic bl, input logic hb, input logic [2:0] row,
                       input logic hp, input logic hw, input logic ig);
      STEP_COMPLETE = 1'b1; BALL_LOST = bl; HIT_BLOCK = hb; HIT_BLOCK_ROW = row;
      HIT_PADDLE = hp; HIT_WALL = hw; IGNORE_DEATH = ig;
      tick();
      STEP_COMPLETE = 1'b0; BALL_LOST = 1'b0; HIT_BLOCK = 1'b0; HIT_BLOCK_ROW = 3'd0;
      HIT_PADDLE = 1'b0; HIT_WALL = 1'b0; IGNORE_DEATH = 1'b0;
   endtask

   // Adds exactly n points, letting each hit drain fully before the next
   task automatic earn(input int n);
      int p;
      while (n > 0) begin
         p = (n >= 6) ? 6 : n;
         step(1'b0, 1'b1, 3'(6 - p), 1'b0, 1'b0, 1'b0);
         repeat (p) tick();
         n -= p;
      end
   endtask

   initial begin
      RESET = 1'b1; STEP_COMPLETE = 1'b0; BALL_LOST = 1'b0; HIT_BLOCK = 1'b0;
      HIT_BLOCK_ROW = 3'd0; HIT_PADDLE = 1'b0; HIT_WALL = 1'b0;
      LEVEL_CLEARED = 1'b0; IGNORE_DEATH = 1'b0;
      tick(); tick();
      check("rst_lives", lives, 5);
      check("rst_level", level, 0);
      check("rst_score", score, 0);
      check("rst_trig", audio_trig, 0);
      check("rst_sel", audio_sel, 0);
      check("rst_over", game_over, 0);
      check("rst_won", game_won, 0);
      check("rst_load", load_level, 0);
      RESET = 1'b0;

      // Block hit on row 0: 6 points drained one per cycle
      step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      check("hit0_trig", audio_trig, 1);
      check("hit0_sel", audio_sel, 3);
      check("hit0_score_now", score, 16'h0000);
      repeat (5) tick();
      check("hit0_score5", score, 16'h0005);
      tick();
      check("hit0_score6", score, 16'h0006);
      check("hit0_trig_low", audio_trig, 0);
      tick();
      check("hit0_drained", score, 16'h0006);

      step(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
      check("prio_lost_sel", audio_sel, 2);
      check("prio_lost_trig", audio_trig, 1);
      check("lost_lives", lives, 4);
      repeat (7) tick();
      check("lost_block_pts", score, 16'h0012);

      step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      check("prio_paddle_sel", audio_sel, 1);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      check("wall_sel", audio_sel, 0);
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      check("ignore_sel", audio_sel, 2);
      check("ignore_lives", lives, 4);
      step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
      check("row5_sel", audio_sel, 8);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("empty_trig", audio_trig, 0);
      check("empty_sel_hold", audio_sel, 8);
      tick();
      check("row5_score", score, 16'h0013);

      // Level clear held into LOAD: one pulse, then counts again back in PLAY
      LEVEL_CLEARED = 1'b1;
      tick();
      check("lc_pulse", load_level, 1);
      check("lc_level1", level, 1);
      pulses = 0;
      repeat (16) begin
         tick();
         pulses += int'(load_level);
      end
      check("lc_single_pulse", pulses, 0);
      tick();
      check("lc_again_pulse", load_level, 1);
      check("lc_level2", level, 2);
      LEVEL_CLEARED = 1'b0;
      repeat (15) tick();
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      check("load_ignores_step", audio_trig, 0);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      check("play_after_load", audio_trig, 1);

      LEVEL_CLEARED = 1'b1;
      tick();
      LEVEL_CLEARED = 1'b0;
      check("lc_level3", level, 3);
      repeat (16) tick();
      LEVEL_CLEARED = 1'b1;
      tick();
      LEVEL_CLEARED = 1'b0;
      check("wrap_level0", level, 0);
      check("wrap_pulse", load_level, 1);
      check("wrap_not_over", game_over, 0);
      check("nw_won", game_won_nw, 1);
      check("nw_over", game_over_nw, 1);
      check("nw_level", level_nw, 3);
      check("nw_no_pulse", load_level_nw, 0);
      repeat (16) tick();

      // Score climb: extra lives at each thousand, capped at 7, then 9999 saturation
      earn(982);
      check("s0995", score, 16'h0995);
      check("s0995_lives", lives, 4);
      earn(6);
      check("s1001", score, 16'h1001);
      check("s1001_lives", lives, 5);
      earn(999);
      check("s2000_lives", lives, 6);
      earn(1000);
      check("s3000_lives", lives, 7);
      earn(1000);
      check("s4000", score, 16'h4000);
      check("s4000_lives_cap", lives, 7);
      earn(5998);
      check("s9998", score, 16'h9998);
      earn(6);
      check("s9999_sat", score, 16'h9999);
      check("s9999_lives", lives, 7);
      check("nw_won_ignores", score_nw, 16'h0013);
      check("nw_still_won", game_won_nw, 1);

      // Losing every life; final loss coincides with a level clear
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("rst2_lives", lives, 5);
      check("rst2_nw_won", game_won_nw, 0);
      repeat (4) step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("lives1", lives, 1);
      check("lives1_not_over", game_over, 0);
      LEVEL_CLEARED = 1'b1;
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      LEVEL_CLEARED = 1'b0;
      check("lives0", lives, 0);
      check("over", game_over, 1);
      check("over_not_won", game_won, 0);
      check("over_level", level, 0);
      check("over_no_load", load_level, 0);
      check("over_last_sel", audio_sel, 2);
      step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      check("over_no_trig", audio_trig, 0);
      check("over_sel_hold", audio_sel, 2);
      repeat (3) tick();
      check("over_no_score", score, 0);
      check("over_lives", lives, 0);
      check("over_absorb", game_over, 1);

      // RESET during LOAD with other inputs active
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      check("row2_sel", audio_sel, 5);
      LEVEL_CLEARED = 1'b1;
      tick();
      LEVEL_CLEARED = 1'b0;
      check("midload_pulse", load_level, 1);
      repeat (2) tick();
      RESET = 1'b1; STEP_COMPLETE = 1'b1; HIT_WALL = 1'b1; LEVEL_CLEARED = 1'b1;
      tick();
      RESET = 1'b0; STEP_COMPLETE = 1'b0; HIT_WALL = 1'b0; LEVEL_CLEARED = 1'b0;
      check("mid_rst_level", level, 0);
      check("mid_rst_score", score, 0);
      check("mid_rst_sel", audio_sel, 0);
      check("mid_rst_trig", audio_trig, 0);
      check("mid_rst_load", load_level, 0);
      check("mid_rst_lives", lives, 5);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      check("mid_rst_play", audio_trig, 1);

      // 14 back-to-back row-0 hits: accumulator clips at 63, 75 points survive
      STEP_COMPLETE = 1'b1; HIT_BLOCK = 1'b1; HIT_BLOCK_ROW = 3'd0;
      repeat (14) tick();
      STEP_COMPLETE = 1'b0; HIT_BLOCK = 1'b0;
      repeat (70) tick();
      check("pend_sat_score", score, 16'h0075);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
